// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Data-memory request/response bus between the memory-stage
//               access sequencer (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [3:0]       mem_be;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_ready;
   logic [WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : RV32I memory-stage access sequencer: turns an M-stage
//               load/store into a held memory request, stalls the front of
//               the pipeline until the memory responds and returns the
//               extended load data. Define STALL_COUNT_EN to enable the
//               stall_cycles performance counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [1:0]       resultsrcM,
   input  wire logic             memwriteM,
   input  wire logic [2:0]       funct3M,
   input  wire logic [WIDTH-1:0] aluresultM,
   input  wire logic [WIDTH-1:0] writedataM,
   mem_access_ctrl_if.master     mem,
   output logic                  stall_o,
   output logic                  flush_w,
   output logic [WIDTH-1:0]      loaddata_o,
   output logic                  load_valid,
   output logic                  misalign_o,
   output logic                  timeout_o,
   output logic [31:0]           stall_cycles
);

   localparam logic [1:0] c_idle    = 2'd0;
   localparam logic [1:0] c_req     = 2'd1;
   localparam logic [1:0] c_done    = 2'd2;
   localparam logic [7:0] c_timeout = 8'(TIMEOUT);

   logic [1:0]       r_state;
   logic [7:0]       r_wait_cnt;
   logic             r_is_load;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [1:0]       r_off;

   logic             w_access;
   logic             w_misalign;
   logic             w_start;
   logic [7:0]       w_wait_next;
   logic [3:0]       w_be;
   logic [WIDTH-1:0] w_wdata;
   logic [7:0]       w_lane_b;
   logic [15:0]      w_lane_h;
   logic [WIDTH-1:0] w_ext;

   assign w_access    = memwriteM | (resultsrcM == 2'b01);
   // funct3[1] set covers both word (10) and the reserved 11, treated as word
   assign w_misalign  = ((funct3M[1:0] == 2'b01) & aluresultM[0]) |
                        (funct3M[1] & (aluresultM[1:0] != 2'b00));
   assign w_start     = (r_state == c_idle) & w_access & ~w_misalign;
   assign w_wait_next = r_wait_cnt + 8'd1;

   assign stall_o     = w_start | (r_state == c_req);
   assign flush_w     = stall_o;
   assign misalign_o  = (r_state == c_idle) & w_access & w_misalign;
   assign mem.mem_req = (r_state == c_req);

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = writedataM;
      case (funct3M[1:0])
         2'b00: begin
            w_be    = 4'b0001 << aluresultM[1:0];
            w_wdata = {4{writedataM[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << aluresultM[1:0];
            w_wdata = {2{writedataM[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_lane_b = mem.mem_rdata[{r_off, 3'b000} +: 8];
   assign w_lane_h = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

   always_comb begin
      w_ext = mem.mem_rdata;
      case (r_size)
         2'b00:   w_ext = {{(WIDTH-8){~r_unsigned & w_lane_b[7]}}, w_lane_b};
         2'b01:   w_ext = {{(WIDTH-16){~r_unsigned & w_lane_h[15]}}, w_lane_h};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= c_idle;
         r_wait_cnt    <= 8'd0;
         r_is_load     <= 1'b0;
         r_size        <= 2'b00;
         r_unsigned    <= 1'b0;
         r_off         <= 2'b00;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= 4'b0000;
         mem.mem_wdata <= '0;
         loaddata_o    <= '0;
         load_valid    <= 1'b0;
         timeout_o     <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         timeout_o  <= 1'b0;
         case (r_state)
            c_idle: begin
               if (w_start) begin
                  mem.mem_addr  <= {aluresultM[WIDTH-1:2], 2'b00};
                  mem.mem_we    <= memwriteM;
                  mem.mem_be    <= w_be;
                  mem.mem_wdata <= w_wdata;
                  r_is_load     <= ~memwriteM;
                  r_size        <= funct3M[1:0];
                  r_unsigned    <= funct3M[2];
                  r_off         <= aluresultM[1:0];
                  r_wait_cnt    <= 8'd0;
                  r_state       <= c_req;
               end
            end
            c_req: begin
               r_wait_cnt <= w_wait_next;
               // ready takes priority over a timeout in the same cycle
               if (mem.mem_ready) begin
                  if (r_is_load) begin
                     loaddata_o <= w_ext;
                  end
                  load_valid <= r_is_load;
                  r_state    <= c_done;
               end else if (w_wait_next == c_timeout) begin
                  loaddata_o <= '0;
                  timeout_o  <= 1'b1;
                  r_state    <= c_done;
               end
            end
            c_done:  r_state <= c_idle;
            default: r_state <= c_idle;
         endcase
      end
   end

`ifdef STALL_COUNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= 32'd0;
      end else if (stall_o) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cnt;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
